// File: rtl/ibex_rf_wport_arbiter_if.sv
// ibex_rf_wport_arbiter_if
//   Bundle of the writeback-side signals of the register-file write-port
//   arbiter. Signal names keep the original port names of the arbiter.
//   master : writeback/ID side (drives requests and read addresses)
//   slave  : arbiter side (drives grant, RF write port, forwarding, status)
//   Signals:
//     ex_*     EX writeback request/address/data, ex_gnt_o grant back
//     lsu_*    LSU load writeback request/address/data (never stalled)
//     rf_*     register-file write port W1
//     raddr_*  ID read addresses, fwd_* forwarding of the parked entry
//     busy_o   holding buffer valid, conflict_cnt_o saturating stall count
interface ibex_rf_wport_arbiter_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned CntWidth  = 16
);
  logic                 ex_req_i;
  logic [4:0]           ex_addr_i;
  logic [DataWidth-1:0] ex_wdata_i;
  logic                 ex_gnt_o;
  logic                 lsu_req_i;
  logic [4:0]           lsu_addr_i;
  logic [DataWidth-1:0] lsu_wdata_i;
  logic                 rf_we_o;
  logic [4:0]           rf_waddr_o;
  logic [DataWidth-1:0] rf_wdata_o;
  logic [4:0]           raddr_a_i;
  logic [4:0]           raddr_b_i;
  logic                 fwd_a_valid_o;
  logic                 fwd_b_valid_o;
  logic [DataWidth-1:0] fwd_data_o;
  logic                 busy_o;
  logic [CntWidth-1:0]  conflict_cnt_o;

  modport master (
    output ex_req_i, ex_addr_i, ex_wdata_i,
    output lsu_req_i, lsu_addr_i, lsu_wdata_i,
    output raddr_a_i, raddr_b_i,
    input  ex_gnt_o, rf_we_o, rf_waddr_o, rf_wdata_o,
    input  fwd_a_valid_o, fwd_b_valid_o, fwd_data_o,
    input  busy_o, conflict_cnt_o
  );

  modport slave (
    input  ex_req_i, ex_addr_i, ex_wdata_i,
    input  lsu_req_i, lsu_addr_i, lsu_wdata_i,
    input  raddr_a_i, raddr_b_i,
    output ex_gnt_o, rf_we_o, rf_waddr_o, rf_wdata_o,
    output fwd_a_valid_o, fwd_b_valid_o, fwd_data_o,
    output busy_o, conflict_cnt_o
  );
endinterface

// File: rtl/ibex_rf_wport_arbiter.sv
// ibex_rf_wport_arbiter
//   Shares the single register-file write port W1 between EX writeback and
//   LSU load writeback. LSU writes always win the port; a colliding EX write
//   is parked in a one-entry holding buffer and drained on the next free
//   slot. The parked entry is forwarded to ID on a read-address match.
//   Ports:
//     clk_i   clock
//     rst_ni  asynchronous active-low reset
//     bus     slave side of ibex_rf_wport_arbiter_if (requests, RF write
//             port, forwarding, busy and saturating conflict counter)
//   Parameters:
//     DataWidth  register data width (must match the interface)
//     RV32E      1: writes to x16..x31 are dropped as null writes
//     CntWidth   conflict counter width (must match the interface)
module ibex_rf_wport_arbiter #(
  parameter int unsigned DataWidth = 32,
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  ibex_rf_wport_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  state_e               state_q, state_d;
  logic [4:0]           hold_addr_q, hold_addr_d;
  logic [DataWidth-1:0] hold_data_q, hold_data_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;

  logic                 ex_gnt;
  logic                 rf_we;
  logic [4:0]           rf_waddr;
  logic [DataWidth-1:0] rf_wdata;
  logic                 load_hold;
  logic                 ex_null;
  logic                 lsu_null;
  logic                 supersede;
  logic                 hold_valid;

  // x0 is never written; in RV32E the upper half of the file does not exist.
  function automatic logic is_null(input logic [4:0] addr);
    return (addr == 5'd0) || (RV32E && addr[4]);
  endfunction

  assign ex_null    = is_null(bus.ex_addr_i);
  assign lsu_null   = is_null(bus.lsu_addr_i);
  assign hold_valid = (state_q == HOLD);
  // An LSU write to the parked register is younger and makes the entry stale.
  assign supersede  = bus.lsu_req_i && (bus.lsu_addr_i == hold_addr_q);

  // State register and holding buffer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.lsu_req_i && bus.ex_req_i && !ex_null) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.lsu_req_i) begin
          if (supersede) begin
            state_d = IDLE;
          end
        end else if (bus.ex_req_i && !ex_null) begin
          state_d = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: write-port mux, EX grant and buffer load
  always_comb begin
    ex_gnt    = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    load_hold = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.lsu_req_i) begin
          if (!lsu_null) begin
            rf_we    = 1'b1;
            rf_waddr = bus.lsu_addr_i;
            rf_wdata = bus.lsu_wdata_i;
          end
          ex_gnt    = bus.ex_req_i;
          load_hold = bus.ex_req_i && !ex_null;
        end else if (bus.ex_req_i) begin
          ex_gnt = 1'b1;
          if (!ex_null) begin
            rf_we    = 1'b1;
            rf_waddr = bus.ex_addr_i;
            rf_wdata = bus.ex_wdata_i;
          end
        end
      end
      HOLD: begin
        if (bus.lsu_req_i) begin
          if (!lsu_null) begin
            rf_we    = 1'b1;
            rf_waddr = bus.lsu_addr_i;
            rf_wdata = bus.lsu_wdata_i;
          end
        end else begin
          // Drain the parked entry; a new EX write may refill the buffer
          // in the same cycle, which keeps same-register ordering intact.
          rf_we     = 1'b1;
          rf_waddr  = hold_addr_q;
          rf_wdata  = hold_data_q;
          ex_gnt    = bus.ex_req_i;
          load_hold = bus.ex_req_i && !ex_null;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    if (load_hold) begin
      hold_addr_d = bus.ex_addr_i;
      hold_data_d = bus.ex_wdata_i;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.ex_req_i && !ex_gnt && (cnt_q != '1)) begin
      cnt_d = cnt_q + CntWidth'(1);
    end
  end

  assign bus.ex_gnt_o       = ex_gnt;
  assign bus.rf_we_o        = rf_we;
  assign bus.rf_waddr_o     = rf_waddr;
  assign bus.rf_wdata_o     = rf_wdata;
  assign bus.busy_o         = hold_valid;
  assign bus.conflict_cnt_o = cnt_q;
  assign bus.fwd_a_valid_o  = hold_valid && (bus.raddr_a_i == hold_addr_q) &&
                              (bus.raddr_a_i != 5'd0);
  assign bus.fwd_b_valid_o  = hold_valid && (bus.raddr_b_i == hold_addr_q) &&
                              (bus.raddr_b_i != 5'd0);
  assign bus.fwd_data_o     = hold_valid ? hold_data_q : '0;

  // A parked entry is never a null write, and the port never writes x0.
  a_hold_not_null: assert property (@(posedge clk_i) disable iff (!rst_ni)
    hold_valid |-> !is_null(hold_addr_q));
  a_we_not_null: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rf_we |-> !is_null(rf_waddr));

endmodule

// File: tb/tb_ibex_rf_wport_arbiter.sv
module tb_ibex_rf_wport_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ex_req = 1'b0, lsu_req = 1'b0;
  logic [4:0]  ex_addr = '0, lsu_addr = '0, raddr_a = '0, raddr_b = '0;
  logic [31:0] ex_wdata = '0, lsu_wdata = '0;

  ibex_rf_wport_arbiter_if #(.DataWidth(32), .CntWidth(16)) bus0 ();
  ibex_rf_wport_arbiter_if #(.DataWidth(32), .CntWidth(3))  bus1 ();

  assign bus0.ex_req_i = ex_req;     assign bus1.ex_req_i = ex_req;
  assign bus0.ex_addr_i = ex_addr;   assign bus1.ex_addr_i = ex_addr;
  assign bus0.ex_wdata_i = ex_wdata; assign bus1.ex_wdata_i = ex_wdata;
  assign bus0.lsu_req_i = lsu_req;   assign bus1.lsu_req_i = lsu_req;
  assign bus0.lsu_addr_i = lsu_addr; assign bus1.lsu_addr_i = lsu_addr;
  assign bus0.lsu_wdata_i = lsu_wdata; assign bus1.lsu_wdata_i = lsu_wdata;
  assign bus0.raddr_a_i = raddr_a;   assign bus1.raddr_a_i = raddr_a;
  assign bus0.raddr_b_i = raddr_b;   assign bus1.raddr_b_i = raddr_b;

  ibex_rf_wport_arbiter #(.DataWidth(32), .RV32E(1'b0), .CntWidth(16)) u_dut0 (
    .clk_i (clk), .rst_ni(rst_n), .bus(bus0.slave));
  ibex_rf_wport_arbiter #(.DataWidth(32), .RV32E(1'b1), .CntWidth(3)) u_dut1 (
    .clk_i (clk), .rst_ni(rst_n), .bus(bus1.slave));

  // Register file images built from what each DUT actually writes.
  logic [31:0] rf0 [32];
  logic [31:0] rf1 [32];
  always @(posedge clk) if (bus0.rf_we_o) rf0[bus0.rf_waddr_o] <= bus0.rf_wdata_o;
  always @(posedge clk) if (bus1.rf_we_o) rf1[bus1.rf_waddr_o] <= bus1.rf_wdata_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // Reference model: one accepted-but-unwritten write per instance, plus the
  // architectural register file in acceptance order.
  bit          mv [2];
  logic [4:0]  ma [2];
  logic [31:0] md [2];
  int unsigned mcnt [2];
  bit          mg [2];
  logic [31:0] arch [2][32];
  bit          awr [2][32];

  function automatic bit mnull(input logic [4:0] a, input bit rv32e);
    return (a == 5'd0) || (rv32e && a >= 5'd16);
  endfunction

  task automatic accept(input int k, input bit rv32e, input logic [4:0] a, input logic [31:0] d);
    if (!mnull(a, rv32e)) begin
      arch[k][a] = d;
      awr[k][a]  = 1'b1;
    end
  endtask

  task automatic model_check(input int k, input bit rv32e, input int unsigned cmax);
    logic        egnt, ewe, efa, efb, ebusy;
    logic [4:0]  ewa;
    logic [31:0] ewd, efd;
    logic        agnt, awe, afa, afb, abusy;
    logic [4:0]  awa;
    logic [31:0] awd, afd, acnt;
    agnt  = (k == 0) ? bus0.ex_gnt_o      : bus1.ex_gnt_o;
    awe   = (k == 0) ? bus0.rf_we_o       : bus1.rf_we_o;
    awa   = (k == 0) ? bus0.rf_waddr_o    : bus1.rf_waddr_o;
    awd   = (k == 0) ? bus0.rf_wdata_o    : bus1.rf_wdata_o;
    afa   = (k == 0) ? bus0.fwd_a_valid_o : bus1.fwd_a_valid_o;
    afb   = (k == 0) ? bus0.fwd_b_valid_o : bus1.fwd_b_valid_o;
    afd   = (k == 0) ? bus0.fwd_data_o    : bus1.fwd_data_o;
    abusy = (k == 0) ? bus0.busy_o        : bus1.busy_o;
    acnt  = (k == 0) ? 32'(bus0.conflict_cnt_o) : 32'(bus1.conflict_cnt_o);

    ebusy = mv[k];
    efd   = md[k];
    efa   = mv[k] && (raddr_a == ma[k]) && (raddr_a != 5'd0);
    efb   = mv[k] && (raddr_b == ma[k]) && (raddr_b != 5'd0);
    egnt = 1'b0; ewe = 1'b0; ewa = '0; ewd = '0;
    if (lsu_req) begin
      if (!mnull(lsu_addr, rv32e)) begin ewe = 1'b1; ewa = lsu_addr; ewd = lsu_wdata; end
      accept(k, rv32e, lsu_addr, lsu_wdata);
      if (mv[k]) begin
        if (ma[k] == lsu_addr) mv[k] = 1'b0;
      end else if (ex_req) begin
        egnt = 1'b1;
        accept(k, rv32e, ex_addr, ex_wdata);
        if (!mnull(ex_addr, rv32e)) begin mv[k] = 1'b1; ma[k] = ex_addr; md[k] = ex_wdata; end
      end
    end else if (mv[k]) begin
      ewe = 1'b1; ewa = ma[k]; ewd = md[k];
      mv[k] = 1'b0;
      if (ex_req) begin
        egnt = 1'b1;
        accept(k, rv32e, ex_addr, ex_wdata);
        if (!mnull(ex_addr, rv32e)) begin mv[k] = 1'b1; ma[k] = ex_addr; md[k] = ex_wdata; end
      end
    end else if (ex_req) begin
      egnt = 1'b1;
      accept(k, rv32e, ex_addr, ex_wdata);
      if (!mnull(ex_addr, rv32e)) begin ewe = 1'b1; ewa = ex_addr; ewd = ex_wdata; end
    end

    check_eq($sformatf("gnt%0d", k), 32'(agnt), 32'(egnt));
    check_eq($sformatf("we%0d", k), 32'(awe), 32'(ewe));
    if (ewe) begin
      check_eq($sformatf("waddr%0d", k), 32'(awa), 32'(ewa));
      check_eq($sformatf("wdata%0d", k), awd, ewd);
    end
    check_eq($sformatf("busy%0d", k), 32'(abusy), 32'(ebusy));
    check_eq($sformatf("fwda%0d", k), 32'(afa), 32'(efa));
    check_eq($sformatf("fwdb%0d", k), 32'(afb), 32'(efb));
    if (ebusy) check_eq($sformatf("fwdd%0d", k), afd, efd);
    check_eq($sformatf("cnt%0d", k), acnt, mcnt[k]);
    if (ex_req && !egnt && mcnt[k] < cmax) mcnt[k]++;
    mg[k] = egnt;
  endtask

  // Drive one cycle of inputs after the edge, check both DUTs mid-cycle.
  task automatic step(input logic er, input logic [4:0] ea, input logic [31:0] ed,
                      input logic lr, input logic [4:0] la, input logic [31:0] ld,
                      input logic [4:0] ra, input logic [4:0] rb);
    @(posedge clk); #1;
    ex_req = er; ex_addr = ea; ex_wdata = ed;
    lsu_req = lr; lsu_addr = la; lsu_wdata = ld;
    raddr_a = ra; raddr_b = rb;
    @(negedge clk);
    model_check(0, 1'b0, 32'hFFFF);
    model_check(1, 1'b1, 7);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 9) < 8) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(16, 19));
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      mv[k] = 1'b0; ma[k] = '0; md[k] = '0; mcnt[k] = 0; mg[k] = 1'b1;
      for (int r = 0; r < 32; r++) begin arch[k][r] = '0; awr[k][r] = 1'b0; end
    end
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(bus0.busy_o), 32'd0);
    check_eq("rst_we", 32'(bus0.rf_we_o), 32'd0);
    check_eq("rst_cnt", 32'(bus1.conflict_cnt_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1) no requests
    idle();
    check_eq("t1_we", 32'(bus0.rf_we_o), 32'd0);
    check_eq("t1_waddr", 32'(bus0.rf_waddr_o), 32'd0);
    check_eq("t1_wdata", bus0.rf_wdata_o, 32'd0);
    // 2) EX alone
    step(1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, '0, '0, '0, '0);
    check_eq("t2_we", 32'(bus0.rf_we_o), 32'd1);
    check_eq("t2_waddr", 32'(bus0.rf_waddr_o), 32'd5);
    check_eq("t2_gnt", 32'(bus0.ex_gnt_o), 32'd1);
    // 3) collision then drain
    step(1'b1, 5'd7, 32'h22, 1'b1, 5'd3, 32'h11, '0, '0);
    check_eq("t3_waddr0", 32'(bus0.rf_waddr_o), 32'd3);
    idle();
    check_eq("t3_busy1", 32'(bus0.busy_o), 32'd1);
    check_eq("t3_waddr1", 32'(bus0.rf_waddr_o), 32'd7);
    check_eq("t3_wdata1", bus0.rf_wdata_o, 32'h22);
    idle();
    check_eq("t3_busy2", 32'(bus0.busy_o), 32'd0);
    // 4) back-to-back hold
    step(1'b1, 5'd7, 32'h22, 1'b1, 5'd3, 32'h11, '0, '0);
    step(1'b1, 5'd8, 32'h88, 1'b1, 5'd4, 32'h44, '0, '0);
    check_eq("t4_waddr1", 32'(bus0.rf_waddr_o), 32'd4);
    check_eq("t4_gnt1", 32'(bus0.ex_gnt_o), 32'd0);
    step(1'b1, 5'd8, 32'h88, 1'b0, '0, '0, '0, '0);
    check_eq("t4_cnt", 32'(bus0.conflict_cnt_o), 32'd1);
    check_eq("t4_waddr2", 32'(bus0.rf_waddr_o), 32'd7);
    check_eq("t4_gnt2", 32'(bus0.ex_gnt_o), 32'd1);
    idle();
    check_eq("t4_waddr3", 32'(bus0.rf_waddr_o), 32'd8);
    // 5) supersede
    step(1'b1, 5'd7, 32'h22, 1'b1, 5'd3, 32'h11, '0, '0);
    step(1'b0, '0, '0, 1'b1, 5'd7, 32'h33, '0, '0);
    check_eq("t5_wdata", bus0.rf_wdata_o, 32'h33);
    idle();
    check_eq("t5_busy", 32'(bus0.busy_o), 32'd0);
    check_eq("t5_we", 32'(bus0.rf_we_o), 32'd0);
    // 6) forward, null, RV32E
    step(1'b1, 5'd9, 32'h99, 1'b1, 5'd1, 32'h01, '0, '0);
    step(1'b0, '0, '0, 1'b0, '0, '0, 5'd9, 5'd0);
    check_eq("t6_fwda", 32'(bus0.fwd_a_valid_o), 32'd1);
    check_eq("t6_fwdd", bus0.fwd_data_o, 32'h99);
    check_eq("t6_fwdb", 32'(bus0.fwd_b_valid_o), 32'd0);
    step(1'b1, 5'd0, 32'hDEAD, 1'b0, '0, '0, '0, '0);
    check_eq("t6_x0_we", 32'(bus0.rf_we_o), 32'd0);
    check_eq("t6_x0_gnt", 32'(bus0.ex_gnt_o), 32'd1);
    step(1'b1, 5'd20, 32'hBEEF, 1'b0, '0, '0, '0, '0);
    check_eq("t6_e_we", 32'(bus1.rf_we_o), 32'd0);
    check_eq("t6_i_we", 32'(bus0.rf_we_o), 32'd1);

    // Random traffic; EX request held stable until both DUTs granted it.
    for (int i = 0; i < 2000; i++) begin
      logic        er, lr;
      logic [4:0]  ea, la;
      logic [31:0] ed, ld;
      if (ex_req && (!mg[0] || !mg[1])) begin
        er = ex_req; ea = ex_addr; ed = ex_wdata;
      end else begin
        er = 1'($urandom_range(0, 1)); ea = rnd_addr(); ed = $urandom();
      end
      lr = 1'($urandom_range(0, 1)); la = rnd_addr(); ld = $urandom();
      step(er, ea, ed, lr, la, ld, 5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)));
    end
    idle();
    idle();
    @(posedge clk); #1;
    for (int r = 0; r < 32; r++) begin
      if (awr[0][r]) check_eq($sformatf("rf0_x%0d", r), rf0[r], arch[0][r]);
      if (awr[1][r]) check_eq($sformatf("rf1_x%0d", r), rf1[r], arch[1][r]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
